// File: rtl/clock_measure_pkg.sv
// Shared defaults and state type for the clock-measurement block.
package clock_measure_pkg;

    localparam int DEF_CLK_HZ = 100_000_000;
    localparam int DEF_CNT_W  = 27;

    typedef enum logic {
        IDLE    = 1'b0,
        MEASURE = 1'b1
    } state_t;

endpackage

// File: rtl/sync_edge_detect.sv
// Multi-flop synchronizer for an asynchronous input plus a registered rising-edge pulse.
// The pulse appears SYNC_STAGES+1 cycles after the input rises; o_level is the synchronized level.
module sync_edge_detect #(
    parameter int SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_sig,
    output logic o_level,
    output logic o_rise
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    logic                   r_rise;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync <= '0;
            r_prev <= 1'b0;
            r_rise <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_sig};
            r_prev <= r_sync[SYNC_STAGES-1];
            r_rise <= r_sync[SYNC_STAGES-1] & ~r_prev;
        end
    end

    assign o_level = r_sync[SYNC_STAGES-1];
    assign o_rise  = r_rise;

endmodule

// File: rtl/measure_clock_period.sv
// Period / frequency / loss-of-signal checker for a slow external square wave.
// Define MEASURE_DUTY_EN to build the high-time counter; otherwise high_cycles is tied to 0.
module measure_clock_period
    import clock_measure_pkg::*;
#(
    parameter int CLK_HZ         = DEF_CLK_HZ,
    parameter int GATE_CYCLES    = CLK_HZ,
    parameter int CNT_W          = DEF_CNT_W,
    parameter int TIMEOUT_CYCLES = CLK_HZ,
    parameter int SYNC_STAGES    = 2
) (
    input  logic             CLK100MHZ,
    input  logic             RST,
    input  logic             sig_in,
    output logic [CNT_W-1:0] period_cycles,
    output logic             period_valid,
    output logic [CNT_W-1:0] freq_hz,
    output logic             freq_valid,
    output logic [CNT_W-1:0] high_cycles,
    output logic             no_signal
);

    localparam logic [CNT_W-1:0] GATE_LAST = CNT_W'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic w_level;
    logic w_rise;

    sync_edge_detect #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .i_clk  (CLK100MHZ),
        .i_rst  (RST),
        .i_sig  (sig_in),
        .o_level(w_level),
        .o_rise (w_rise)
    );

    state_t           r_state;
    logic [CNT_W-1:0] r_per_ctr;
    logic [CNT_W-1:0] r_period;
    logic             r_period_valid;
    logic             r_no_signal;

    // Timeout fires on the cycle the counter would reach TIMEOUT_CYCLES.
    always_ff @(posedge CLK100MHZ) begin
        if (RST) begin
            r_state        <= IDLE;
            r_per_ctr      <= '0;
            r_period       <= '0;
            r_period_valid <= 1'b0;
            r_no_signal    <= 1'b0;
        end else begin
            r_period_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_rise) begin
                        r_state     <= MEASURE;
                        r_per_ctr   <= CNT_ONE;
                        r_no_signal <= 1'b0;
                    end
                end
                MEASURE: begin
                    if (w_rise) begin
                        r_period       <= r_per_ctr;
                        r_period_valid <= 1'b1;
                        r_per_ctr      <= CNT_ONE;
                    end else if (r_per_ctr == TO_LAST) begin
                        r_no_signal <= 1'b1;
                        r_state     <= IDLE;
                        r_per_ctr   <= '0;
                    end else begin
                        r_per_ctr <= r_per_ctr + CNT_ONE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    logic [CNT_W-1:0] r_gate_ctr;
    logic [CNT_W-1:0] r_edge_ctr;
    logic [CNT_W-1:0] r_freq;
    logic             r_freq_valid;
    logic [CNT_W-1:0] w_edge_sum;

    // Saturating edge count including a rise that lands on the current cycle.
    assign w_edge_sum = (w_rise && (r_edge_ctr != CNT_MAX)) ? r_edge_ctr + CNT_ONE : r_edge_ctr;

    always_ff @(posedge CLK100MHZ) begin
        if (RST) begin
            r_gate_ctr   <= '0;
            r_edge_ctr   <= '0;
            r_freq       <= '0;
            r_freq_valid <= 1'b0;
        end else begin
            r_freq_valid <= 1'b0;
            if (r_gate_ctr == GATE_LAST) begin
                r_gate_ctr   <= '0;
                r_freq       <= w_edge_sum;
                r_freq_valid <= 1'b1;
                r_edge_ctr   <= '0;
            end else begin
                r_gate_ctr <= r_gate_ctr + CNT_ONE;
                r_edge_ctr <= w_edge_sum;
            end
        end
    end

`ifdef MEASURE_DUTY_EN
    logic [CNT_W-1:0] r_hi_ctr;
    logic [CNT_W-1:0] r_high;

    // The rise cycle itself belongs to the new period, so the counter restarts with the current level.
    always_ff @(posedge CLK100MHZ) begin
        if (RST) begin
            r_hi_ctr <= '0;
            r_high   <= '0;
        end else if (w_rise) begin
            if (r_state == MEASURE) begin
                r_high <= r_hi_ctr;
            end
            r_hi_ctr <= CNT_W'(w_level);
        end else if ((r_state == MEASURE) && w_level && (r_hi_ctr != CNT_MAX)) begin
            r_hi_ctr <= r_hi_ctr + CNT_ONE;
        end
    end

    assign high_cycles = r_high;
`else
    logic w_unused_level;
    assign w_unused_level = w_level;
    assign high_cycles    = '0;
`endif

    assign period_cycles = r_period;
    assign period_valid  = r_period_valid;
    assign freq_hz       = r_freq;
    assign freq_valid    = r_freq_valid;
    assign no_signal     = r_no_signal;

endmodule

// File: tb/tb_measure_clock_period.sv
// Self-checking bench for measure_clock_period; expectations come from rise times of the driven wave.
module tb_measure_clock_period;

    localparam int GATE    = 10_000;
    localparam int TIMEOUT = 20_000;
    localparam int CNT_W   = 27;
    localparam int SYNC    = 2;
    localparam int LAT     = SYNC + 1;
`ifdef MEASURE_DUTY_EN
    localparam bit DUTY_EN = 1'b1;
`else
    localparam bit DUTY_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             sig_in = 1'b0;
    logic [CNT_W-1:0] period_cycles;
    logic             period_valid;
    logic [CNT_W-1:0] freq_hz;
    logic             freq_valid;
    logic [CNT_W-1:0] high_cycles;
    logic             no_signal;

    measure_clock_period #(
        .CLK_HZ        (100_000_000),
        .GATE_CYCLES   (GATE),
        .CNT_W         (CNT_W),
        .TIMEOUT_CYCLES(TIMEOUT),
        .SYNC_STAGES   (SYNC)
    ) dut (
        .CLK100MHZ    (clk),
        .RST          (rst),
        .sig_in       (sig_in),
        .period_cycles(period_cycles),
        .period_valid (period_valid),
        .freq_hz      (freq_hz),
        .freq_valid   (freq_valid),
        .high_cycles  (high_cycles),
        .no_signal    (no_signal)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: expected internal rise cycles and high time of the period each one closes.
    int pend_c[$];
    int pend_h[$];
    int hi_run    = 0;
    bit last_lvl  = 1'b0;
    bit have_rise = 1'b0;
    int last_rise = 0;
    int win_cnt   = 0;
    int r0        = 0;
    int exp_period = 0, exp_high = 0, exp_freq = 0;
    bit exp_pv = 1'b0, exp_fv = 1'b0, exp_ns = 1'b0;

    function automatic void model_advance(input int k);
        int r, h;
        exp_pv = 1'b0;
        exp_fv = 1'b0;
        if (pend_c.size() > 0 && pend_c[0] == k - 1) begin
            r = pend_c.pop_front();
            h = pend_h.pop_front();
            if (have_rise && (r - last_rise) < TIMEOUT) begin
                exp_pv     = 1'b1;
                exp_period = r - last_rise;
                if (DUTY_EN) exp_high = h;
            end
            have_rise = 1'b1;
            last_rise = r;
            win_cnt++;
        end
        if (k > r0 && ((k - r0) % GATE) == 0) begin
            exp_fv   = 1'b1;
            exp_freq = win_cnt;
            win_cnt  = 0;
        end
        exp_ns = have_rise && ((k - last_rise) >= TIMEOUT);
    endfunction

    task automatic tick(input logic lvl);
        if (lvl && !last_lvl) begin
            pend_c.push_back(cyc + LAT);
            pend_h.push_back(hi_run);
            hi_run = 0;
        end
        if (lvl) hi_run++;
        last_lvl = lvl;
        sig_in   = lvl;
        @(negedge clk);
        model_advance(cyc);
    endtask

    task automatic do_reset(input int n);
        rst      = 1'b1;
        sig_in   = 1'b0;
        last_lvl = 1'b0;
        repeat (n) @(negedge clk);
        rst = 1'b0;
        pend_c.delete();
        pend_h.delete();
        hi_run = 0; have_rise = 1'b0; last_rise = 0; win_cnt = 0; r0 = cyc;
        exp_period = 0; exp_high = 0; exp_freq = 0;
        exp_pv = 1'b0; exp_fv = 1'b0; exp_ns = 1'b0;
    endtask

    task automatic test_reset();
        do_reset(4);
        n_checks++; if (period_cycles !== '0) begin n_fail++; $display("FAIL reset_period got=%0d exp=0", period_cycles); end
        n_checks++; if (period_valid !== 1'b0) begin n_fail++; $display("FAIL reset_pv got=%b exp=0", period_valid); end
        n_checks++; if (freq_hz !== '0) begin n_fail++; $display("FAIL reset_freq got=%0d exp=0", freq_hz); end
        n_checks++; if (freq_valid !== 1'b0) begin n_fail++; $display("FAIL reset_fv got=%b exp=0", freq_valid); end
        n_checks++; if (high_cycles !== '0) begin n_fail++; $display("FAIL reset_high got=%0d exp=0", high_cycles); end
        n_checks++; if (no_signal !== 1'b0) begin n_fail++; $display("FAIL reset_ns got=%b exp=0", no_signal); end
        $display("reset: outputs checked at cycle %0d", cyc);
    endtask

    // Eleven fixed 1000/500 periods, then randomized periods and duty.
    task automatic test_period();
        int p, h;
        for (int seg = 0; seg < 17; seg++) begin
            if (seg < 11) begin
                p = 1000; h = 500;
            end else begin
                p = $urandom_range(400, 1600);
                h = $urandom_range(1, p - 1);
            end
            for (int i = 0; i < p; i++) begin
                tick(i < h);
                n_checks++; if (period_valid !== exp_pv) begin n_fail++; $display("FAIL period_pv cyc=%0d got=%b exp=%b", cyc, period_valid, exp_pv); end
                n_checks++; if (period_cycles !== CNT_W'(exp_period)) begin n_fail++; $display("FAIL period_val cyc=%0d got=%0d exp=%0d", cyc, period_cycles, exp_period); end
                n_checks++; if (high_cycles !== CNT_W'(exp_high)) begin n_fail++; $display("FAIL period_high cyc=%0d got=%0d exp=%0d", cyc, high_cycles, exp_high); end
                n_checks++; if (freq_valid !== exp_fv) begin n_fail++; $display("FAIL period_fv cyc=%0d got=%b exp=%b", cyc, freq_valid, exp_fv); end
                n_checks++; if (freq_hz !== CNT_W'(exp_freq)) begin n_fail++; $display("FAIL period_freq cyc=%0d got=%0d exp=%0d", cyc, freq_hz, exp_freq); end
                n_checks++; if (no_signal !== exp_ns) begin n_fail++; $display("FAIL period_ns cyc=%0d got=%b exp=%b", cyc, no_signal, exp_ns); end
                if (seg < 11 && exp_pv) begin
                    n_checks++; if (period_cycles !== CNT_W'(1000)) begin n_fail++; $display("FAIL period_1000 cyc=%0d got=%0d exp=1000", cyc, period_cycles); end
                end
                if (seg < 11 && exp_fv) begin
                    n_checks++; if (freq_hz !== CNT_W'(10)) begin n_fail++; $display("FAIL freq_10 cyc=%0d got=%0d exp=10", cyc, freq_hz); end
                end
            end
            $display("period: segment %0d period=%0d high=%0d done at cycle %0d", seg, p, h, cyc);
        end
    endtask

    task automatic test_timeout();
        int t_drive, t_ns, pv_seen;
        t_drive = 0;
        t_ns    = -1;
        for (int seg = 0; seg < 3; seg++) begin
            for (int i = 0; i < 800; i++) begin
                if (i == 0) t_drive = cyc;
                tick(i < 400);
                n_checks++; if (period_valid !== exp_pv) begin n_fail++; $display("FAIL to_pre_pv cyc=%0d got=%b exp=%b", cyc, period_valid, exp_pv); end
                n_checks++; if (period_cycles !== CNT_W'(exp_period)) begin n_fail++; $display("FAIL to_pre_period cyc=%0d got=%0d exp=%0d", cyc, period_cycles, exp_period); end
            end
        end
        for (int i = 0; i < TIMEOUT + 200; i++) begin
            tick(1'b0);
            if (no_signal === 1'b1 && t_ns < 0) t_ns = cyc;
            n_checks++; if (no_signal !== exp_ns) begin n_fail++; $display("FAIL to_ns cyc=%0d got=%b exp=%b", cyc, no_signal, exp_ns); end
            n_checks++; if (period_valid !== 1'b0) begin n_fail++; $display("FAIL to_pv cyc=%0d got=%b exp=0", cyc, period_valid); end
            n_checks++; if (period_cycles !== CNT_W'(800)) begin n_fail++; $display("FAIL to_held cyc=%0d got=%0d exp=800", cyc, period_cycles); end
        end
        n_checks++; if (t_ns - (t_drive + LAT) != TIMEOUT) begin n_fail++; $display("FAIL to_delay got=%0d exp=%0d", t_ns - (t_drive + LAT), TIMEOUT); end
        $display("timeout: no_signal rose at cycle %0d, last rise driven at %0d", t_ns, t_drive);
        pv_seen = 0;
        for (int seg = 0; seg < 3; seg++) begin
            for (int i = 0; i < 800; i++) begin
                tick(i < 400);
                if (period_valid === 1'b1) pv_seen++;
                n_checks++; if (no_signal !== exp_ns) begin n_fail++; $display("FAIL restart_ns cyc=%0d got=%b exp=%b", cyc, no_signal, exp_ns); end
                n_checks++; if (period_valid !== exp_pv) begin n_fail++; $display("FAIL restart_pv cyc=%0d got=%b exp=%b", cyc, period_valid, exp_pv); end
                n_checks++; if (period_cycles !== CNT_W'(exp_period)) begin n_fail++; $display("FAIL restart_period cyc=%0d got=%0d exp=%0d", cyc, period_cycles, exp_period); end
            end
        end
        n_checks++; if (pv_seen != 2) begin n_fail++; $display("FAIL restart_count got=%0d exp=2", pv_seen); end
        $display("timeout: restart gave %0d period_valid pulses", pv_seen);
    endtask

    // Internal rise lands on the last cycle of a gate window.
    task automatic test_gate_terminal();
        int  target;
        bit  seen;
        target = cyc + LAT + 20;
        while (((target + 1 - r0) % GATE) != 0) target++;
        while (cyc < target - LAT) begin
            tick(1'b0);
            n_checks++; if (freq_valid !== exp_fv) begin n_fail++; $display("FAIL gate_pre_fv cyc=%0d got=%b exp=%b", cyc, freq_valid, exp_fv); end
            n_checks++; if (freq_hz !== CNT_W'(exp_freq)) begin n_fail++; $display("FAIL gate_pre_freq cyc=%0d got=%0d exp=%0d", cyc, freq_hz, exp_freq); end
        end
        for (int i = 0; i < 50; i++) begin
            tick(1'b1);
            n_checks++; if (freq_valid !== exp_fv) begin n_fail++; $display("FAIL gate_fv cyc=%0d got=%b exp=%b", cyc, freq_valid, exp_fv); end
            n_checks++; if (freq_hz !== CNT_W'(exp_freq)) begin n_fail++; $display("FAIL gate_freq cyc=%0d got=%0d exp=%0d", cyc, freq_hz, exp_freq); end
            n_checks++; if (period_cycles !== CNT_W'(exp_period)) begin n_fail++; $display("FAIL gate_period cyc=%0d got=%0d exp=%0d", cyc, period_cycles, exp_period); end
            if (cyc == target + 1) begin
                n_checks++; if (freq_valid !== 1'b1) begin n_fail++; $display("FAIL gate_term_fv cyc=%0d got=%b exp=1", cyc, freq_valid); end
            end
        end
        $display("gate: rise placed on terminal cycle %0d, closing freq_hz=%0d", target, freq_hz);
        seen = 1'b0;
        for (int i = 0; i < GATE + 5 && !seen; i++) begin
            tick(1'b0);
            if (freq_valid === 1'b1) begin
                seen = 1'b1;
                n_checks++; if (freq_hz !== '0) begin n_fail++; $display("FAIL gate_next_zero cyc=%0d got=%0d exp=0", cyc, freq_hz); end
            end
        end
        n_checks++; if (!seen) begin n_fail++; $display("FAIL gate_next_timeout got=no freq_valid exp=freq_valid within %0d cycles", GATE + 5); end
        $display("gate: following window freq_hz=%0d", freq_hz);
    endtask

    task automatic test_reset_mid();
        int pv_seen;
        for (int i = 0; i < 2750; i++) begin
            tick((i % 1000) < 500);
            n_checks++; if (period_valid !== exp_pv) begin n_fail++; $display("FAIL rm_pre_pv cyc=%0d got=%b exp=%b", cyc, period_valid, exp_pv); end
        end
        do_reset(1);
        n_checks++; if (period_cycles !== '0) begin n_fail++; $display("FAIL rm_period got=%0d exp=0", period_cycles); end
        n_checks++; if (period_valid !== 1'b0) begin n_fail++; $display("FAIL rm_pv got=%b exp=0", period_valid); end
        n_checks++; if (freq_hz !== '0) begin n_fail++; $display("FAIL rm_freq got=%0d exp=0", freq_hz); end
        n_checks++; if (freq_valid !== 1'b0) begin n_fail++; $display("FAIL rm_fv got=%b exp=0", freq_valid); end
        n_checks++; if (high_cycles !== '0) begin n_fail++; $display("FAIL rm_high got=%0d exp=0", high_cycles); end
        n_checks++; if (no_signal !== 1'b0) begin n_fail++; $display("FAIL rm_ns got=%b exp=0", no_signal); end
        pv_seen = 0;
        for (int i = 2751; i < 4700; i++) begin
            tick((i % 1000) < 500);
            if (period_valid === 1'b1) pv_seen++;
            n_checks++; if (period_valid !== exp_pv) begin n_fail++; $display("FAIL rm_pv_seq cyc=%0d got=%b exp=%b", cyc, period_valid, exp_pv); end
            n_checks++; if (period_cycles !== CNT_W'(exp_period)) begin n_fail++; $display("FAIL rm_period_seq cyc=%0d got=%0d exp=%0d", cyc, period_cycles, exp_period); end
            n_checks++; if (freq_valid !== exp_fv) begin n_fail++; $display("FAIL rm_fv_seq cyc=%0d got=%b exp=%b", cyc, freq_valid, exp_fv); end
        end
        n_checks++; if (pv_seen != 1) begin n_fail++; $display("FAIL rm_count got=%0d exp=1", pv_seen); end
        $display("reset_mid: %0d period_valid pulses after mid-period reset", pv_seen);
    endtask

    task automatic test_duty();
        for (int seg = 0; seg < 4; seg++) begin
            for (int i = 0; i < 1000; i++) begin
                tick(i < 250);
                n_checks++; if (period_valid !== exp_pv) begin n_fail++; $display("FAIL duty_pv cyc=%0d got=%b exp=%b", cyc, period_valid, exp_pv); end
                n_checks++; if (high_cycles !== CNT_W'(exp_high)) begin n_fail++; $display("FAIL duty_model cyc=%0d got=%0d exp=%0d", cyc, high_cycles, exp_high); end
                if (seg >= 1 && exp_pv) begin
                    n_checks++; if (high_cycles !== (DUTY_EN ? CNT_W'(250) : CNT_W'(0))) begin n_fail++; $display("FAIL duty_250 cyc=%0d got=%0d exp=%0d", cyc, high_cycles, DUTY_EN ? 250 : 0); end
                end
            end
            $display("duty: period %0d done, high_cycles=%0d", seg, high_cycles);
        end
    endtask

    initial begin
        test_reset();
        test_period();
        test_timeout();
        test_gate_terminal();
        test_reset_mid();
        test_duty();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
